// File: rtl/led_seq_engine.sv
// led_seq_engine: steps a walk/bounce/fill pattern across N_LED outputs on the 1 kHz tick.
// Revision 1.0 - initial release.
`default_nettype none

module led_seq_engine #(
  parameter int N_LED   = 8,
  parameter int STEP_W  = 8,
  parameter bit ACT_LOW = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pls_1k,
  input  logic              i_go,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  input  logic [STEP_W-1:0] i_step,
  input  logic [STEP_W-1:0] i_lead,
  input  logic              i_loop,
  output logic [N_LED-1:0]  o_led_on,
  output logic              o_busy,
  output logic              o_done
);

  // Index must hold the longest sequence (bounce, 2N-2 positions).
  localparam int c_idx_w    = $clog2(2 * N_LED);
  localparam int c_npos_bnc = (N_LED == 1) ? 1 : 2 * N_LED - 2;
  localparam logic [N_LED-1:0] c_off = ACT_LOW ? {N_LED{1'b1}} : {N_LED{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LEAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [STEP_W-1:0]   r_cnt, w_cnt_nxt;
  logic [c_idx_w-1:0]  r_idx, w_idx_nxt;
  logic                r_blank, w_blank_nxt;
  logic [N_LED-1:0]    r_led_on, w_led_nxt;
  logic                r_done, w_done_nxt;
  logic                w_latch;
  logic [1:0]          r_mode;
  logic [STEP_W-1:0]   r_step;
  logic [STEP_W-1:0]   r_lead;
  logic                r_loop;
  logic                w_step_end;
  logic                w_lead_end;
  logic                w_last;

  // Pattern for sequence index k, already in pin polarity.
  function automatic logic [N_LED-1:0] f_show(input logic [1:0] mode, input int k);
    logic [N_LED-1:0] p;
    p = '0;
    for (int b = 0; b < N_LED; b++) begin
      case (mode)
        2'b00:   p[b] = (b == k);
        2'b01:   p[b] = (b == N_LED - 1 - k);
        2'b10:   p[b] = (b == k) || (b == 2 * N_LED - 2 - k);
        default: p[b] = (b <= k);
      endcase
    end
    return ACT_LOW ? ~p : p;
  endfunction

  function automatic int f_last(input logic [1:0] mode);
    return (mode == 2'b10) ? c_npos_bnc - 1 : N_LED - 1;
  endfunction

  assign w_step_end = (r_cnt == r_step - STEP_W'(1));
  assign w_lead_end = (r_cnt == r_lead - STEP_W'(1));
  assign w_last     = (int'(r_idx) == f_last(r_mode));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_blank_nxt = r_blank;
    w_led_nxt   = r_led_on;
    w_done_nxt  = 1'b0;
    w_latch     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_go) begin
          w_latch     = 1'b1;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_blank_nxt = 1'b0;
          w_state_nxt = S_LEAD;
        end
      end
      S_LEAD: begin
        if (r_lead == '0 || (i_pls_1k && w_lead_end)) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
          w_led_nxt   = f_show(r_mode, 0);
        end else if (i_pls_1k) begin
          w_cnt_nxt = r_cnt + STEP_W'(1);
        end
      end
      S_RUN: begin
        if (i_pls_1k) begin
          if (w_step_end) begin
            w_cnt_nxt = '0;
            if (r_blank) begin
              if (r_loop) begin
                w_blank_nxt = 1'b0;
                w_idx_nxt   = '0;
                w_led_nxt   = f_show(r_mode, 0);
              end else begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
                w_led_nxt   = c_off;
              end
            end else if (w_last) begin
              w_blank_nxt = 1'b1;
              w_led_nxt   = c_off;
            end else begin
              w_idx_nxt = r_idx + c_idx_w'(1);
              w_led_nxt = f_show(r_mode, int'(r_idx) + 1);
            end
          end else begin
            w_cnt_nxt = r_cnt + STEP_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_blank_nxt = 1'b0;
      end
    endcase

    // Abort overrides everything, including a same-cycle go.
    if (i_stop) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_blank_nxt = 1'b0;
      w_led_nxt   = c_off;
      w_done_nxt  = 1'b0;
      w_latch     = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_blank  <= 1'b0;
      r_led_on <= c_off;
      r_done   <= 1'b0;
      r_mode   <= 2'b00;
      r_step   <= STEP_W'(1);
      r_lead   <= '0;
      r_loop   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_blank  <= w_blank_nxt;
      r_led_on <= w_led_nxt;
      r_done   <= w_done_nxt;
      if (w_latch) begin
        r_mode <= i_mode;
        r_step <= (i_step == '0) ? STEP_W'(1) : i_step;
        r_lead <= i_lead;
        r_loop <= i_loop;
      end
    end
  end

  assign o_led_on = r_led_on;
  assign o_busy   = (r_state == S_LEAD) || (r_state == S_RUN);
  assign o_done   = r_done;

endmodule

`default_nettype wire
